// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched: run/stop/step scheduler producing a one-cycle processor clock enable.
// Latency: command at edge E0 -> first tick high in the cycle after edge E0+div_q.
// Backpressure: none; stop/cpu_halt override any tick due on the same edge.
module cpu_clk_sched #(
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 31250,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [BURST_W-1:0] burst_n,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_val,
  input  logic               cpu_halt,
  output logic               tick,
  output logic               step_done,
  output logic               running,
  output logic [BURST_W-1:0] ticks_left
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   DEF_DIV_Q = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   div_q;
  logic [BURST_W-1:0] remaining;
  logic [CNT_W-1:0]   div_m1;
  logic               terminal;
  logic               abort;
  logic [BURST_W-1:0] burst_eff;
  logic [CNT_W-1:0]   div_eff;

  // div_q is never zero, so div_q-1 cannot underflow
  assign div_m1    = div_q - CNT_ONE;
  assign terminal  = (cnt == div_m1);
  assign abort     = stop | cpu_halt;
  assign burst_eff = (burst_n == '0) ? BURST_ONE : burst_n;
  assign div_eff   = (div_val == '0) ? CNT_ONE : div_val;

  assign ticks_left = remaining;

  // Scheduler FSM: prescale counter, burst bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HALT;
      cnt       <= '0;
      div_q     <= DEF_DIV_Q;
      remaining <= '0;
      tick      <= 1'b0;
      step_done <= 1'b0;
      running   <= 1'b0;
    end else begin
      tick      <= 1'b0;
      step_done <= 1'b0;
      case (state)
        S_HALT: begin
          cnt <= '0;
          if (div_load) div_q <= div_eff;
          // start takes priority over step when both arrive together
          if (start && !cpu_halt) begin
            state   <= S_RUN;
            running <= 1'b1;
          end else if (step && !cpu_halt) begin
            state     <= S_STEP;
            running   <= 1'b1;
            remaining <= burst_eff;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_HALT;
            running <= 1'b0;
            cnt     <= '0;
          end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_STEP: begin
          if (abort) begin
            // aborted burst: no final tick and no step_done
            state     <= S_HALT;
            running   <= 1'b0;
            cnt       <= '0;
            remaining <= '0;
          end else if (terminal) begin
            cnt       <= '0;
            tick      <= 1'b1;
            remaining <= remaining - BURST_ONE;
            if (remaining == BURST_ONE) begin
              step_done <= 1'b1;
              state     <= S_HALT;
              running   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= S_HALT;
          running <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule
